// File: rtl/except_merge_stage.sv
// Exception-merge stage between MEM and WB: picks upstream or lowest-index local exception,
// registers it, and holds it as a pending trap until acked. Counter built under EXCEPT_PERF_CNT_EN.
module except_merge_stage #(
  parameter int unsigned XLEN = 64,
  parameter int unsigned NSRC = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall,
  input  logic                 flush,
  input  logic                 valid_i,
  input  logic [XLEN-1:0]      pc_i,
  input  logic                 up_except_i,
  input  logic [XLEN-1:0]      up_cause_i,
  input  logic [XLEN-1:0]      up_tval_i,
  input  logic [NSRC-1:0]      src_except_i,
  input  logic [NSRC*XLEN-1:0] src_cause_i,
  input  logic [NSRC*XLEN-1:0] src_tval_i,
  output logic                 except_o,
  output logic [XLEN-1:0]      epc_o,
  output logic [XLEN-1:0]      cause_o,
  output logic [XLEN-1:0]      tval_o,
  output logic                 except_happen_o,
  output logic                 trap_req_o,
  input  logic                 trap_ack_i,
  output logic [31:0]          trap_cnt_o
);

  localparam int unsigned CNT_W = 32;
  localparam logic [0:0]  IDLE  = 1'b0;
  localparam logic [0:0]  PEND  = 1'b1;

  logic [0:0]      state_q, state_d;
  logic            except_q, except_d;
  logic [XLEN-1:0] epc_q, epc_d;
  logic [XLEN-1:0] cause_q, cause_d;
  logic [XLEN-1:0] tval_q, tval_d;

  logic            sel_except;
  logic [XLEN-1:0] sel_cause;
  logic [XLEN-1:0] sel_tval;

  // Upstream wins; otherwise the lowest-index local source of a valid instruction.
  always_comb begin
    sel_except = 1'b0;
    sel_cause  = '0;
    sel_tval   = '0;
    if (up_except_i) begin
      sel_except = 1'b1;
      sel_cause  = up_cause_i;
      sel_tval   = up_tval_i;
    end else if (valid_i) begin
      for (int k = int'(NSRC) - 1; k >= 0; k--) begin
        if (src_except_i[k]) begin
          sel_except = 1'b1;
          sel_cause  = src_cause_i[k*XLEN +: XLEN];
          sel_tval   = src_tval_i[k*XLEN +: XLEN];
        end
      end
    end
  end

  // Next-state and next-register values.
  always_comb begin
    state_d  = state_q;
    except_d = except_q;
    epc_d    = epc_q;
    cause_d  = cause_q;
    tval_d   = tval_q;
    if (flush) begin
      state_d  = IDLE;
      except_d = 1'b0;
      epc_d    = '0;
      cause_d  = '0;
      tval_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!stall) begin
            except_d = sel_except;
            epc_d    = sel_except ? pc_i : '0;
            cause_d  = sel_cause;
            tval_d   = sel_tval;
            if (sel_except) state_d = PEND;
          end
        end
        PEND: begin
          if (trap_ack_i) begin
            state_d  = IDLE;
            except_d = 1'b0;
            epc_d    = '0;
            cause_d  = '0;
            tval_d   = '0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      except_q <= 1'b0;
      epc_q    <= '0;
      cause_q  <= '0;
      tval_q   <= '0;
    end else begin
      state_q  <= state_d;
      except_q <= except_d;
      epc_q    <= epc_d;
      cause_q  <= cause_d;
      tval_q   <= tval_d;
    end
  end

  assign except_o        = except_q;
  assign epc_o           = epc_q;
  assign cause_o         = cause_q;
  assign tval_o          = tval_q;
  assign trap_req_o      = (state_q == PEND);
  assign except_happen_o = valid_i & (|src_except_i) & ~up_except_i & (state_q == IDLE);

`ifdef EXCEPT_PERF_CNT_EN
  logic [CNT_W-1:0] trap_cnt_q;
  logic             ack_fire;

  // Acks count even when they coincide with a flush.
  assign ack_fire = (state_q == PEND) & trap_ack_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      trap_cnt_q <= '0;
    end else if (ack_fire && (trap_cnt_q != {CNT_W{1'b1}})) begin
      trap_cnt_q <= trap_cnt_q + CNT_W'(1);
    end
  end

  assign trap_cnt_o = trap_cnt_q;
`else
  assign trap_cnt_o = CNT_W'(0);
`endif

endmodule

// File: tb/tb_except_merge_stage.sv
// Self-checking bench for except_merge_stage: directed scenarios plus randomized traffic
// against a trap-record reference model.
module tb_except_merge_stage;

  localparam int unsigned XLEN = 64;
  localparam int unsigned NSRC = 2;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 stall, flush, valid_i, up_except_i, trap_ack_i;
  logic [XLEN-1:0]      pc_i, up_cause_i, up_tval_i;
  logic [NSRC-1:0]      src_except_i;
  logic [NSRC*XLEN-1:0] src_cause_i, src_tval_i;
  logic                 except_o, except_happen_o, trap_req_o;
  logic [XLEN-1:0]      epc_o, cause_o, tval_o;
  logic [31:0]          trap_cnt_o;

  int total = 0;
  int bad   = 0;

  // Reference model: the trap record visible at the stage output.
  logic            m_pend;
  logic            m_exc;
  logic [XLEN-1:0] m_epc, m_cause, m_tval;
  logic [31:0]     m_cnt;

  except_merge_stage #(.XLEN(XLEN), .NSRC(NSRC)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .valid_i(valid_i), .pc_i(pc_i),
    .up_except_i(up_except_i), .up_cause_i(up_cause_i), .up_tval_i(up_tval_i),
    .src_except_i(src_except_i), .src_cause_i(src_cause_i), .src_tval_i(src_tval_i),
    .except_o(except_o), .epc_o(epc_o), .cause_o(cause_o), .tval_o(tval_o),
    .except_happen_o(except_happen_o), .trap_req_o(trap_req_o),
    .trap_ack_i(trap_ack_i), .trap_cnt_o(trap_cnt_o)
  );

  always #5 clk = ~clk;

  function automatic logic [XLEN-1:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  task automatic model_reset();
    m_pend = 1'b0; m_exc = 1'b0; m_epc = '0; m_cause = '0; m_tval = '0; m_cnt = 32'd0;
  endtask

  task automatic model_clear(input logic count);
    m_pend = 1'b0; m_exc = 1'b0; m_epc = '0; m_cause = '0; m_tval = '0;
`ifdef EXCEPT_PERF_CNT_EN
    if (count && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
`else
    if (count) m_cnt = 32'd0;
`endif
  endtask

  function automatic logic exp_happen();
    return valid_i && (src_except_i != '0) && !up_except_i && !m_pend;
  endfunction

  // Advance the model with the current inputs, then clock and settle.
  task automatic tick();
    logic            hit;
    logic [XLEN-1:0] c, t;
    hit = 1'b0; c = '0; t = '0;
    if (up_except_i) begin
      hit = 1'b1; c = up_cause_i; t = up_tval_i;
    end else if (valid_i) begin
      for (int k = 0; k < int'(NSRC); k++) begin
        if (!hit && src_except_i[k]) begin
          hit = 1'b1;
          c = src_cause_i[k*XLEN +: XLEN];
          t = src_tval_i[k*XLEN +: XLEN];
        end
      end
    end
    if (flush) model_clear(m_pend && trap_ack_i);
    else if (m_pend) begin
      if (trap_ack_i) model_clear(1'b1);
    end else if (!stall) begin
      m_exc = hit; m_pend = hit; m_cause = c; m_tval = t;
      m_epc = hit ? pc_i : '0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    stall = 0; flush = 0; valid_i = 0; up_except_i = 0; trap_ack_i = 0;
    pc_i = '0; up_cause_i = '0; up_tval_i = '0;
    src_except_i = '0; src_cause_i = '0; src_tval_i = '0;
  endtask

  task automatic capture_src(input logic [XLEN-1:0] pc, input logic [XLEN-1:0] cause);
    quiet();
    valid_i = 1; pc_i = pc; src_except_i = 2'b01;
    src_cause_i[XLEN-1:0] = cause; src_tval_i[XLEN-1:0] = rnd64();
    tick();
    quiet();
  endtask

  task automatic ack();
    quiet();
    trap_ack_i = 1;
    tick();
    trap_ack_i = 0;
  endtask

  task automatic test_reset();
    quiet();
    rst = 1;
    model_reset();
    #12;
    total++;
    if ({except_o, epc_o, cause_o, tval_o, trap_req_o, trap_cnt_o} !== '0) begin
      bad++;
      $display("FAIL reset: exc=%b epc=%h cause=%h tval=%h req=%b cnt=%0d, required all 0",
               except_o, epc_o, cause_o, tval_o, trap_req_o, trap_cnt_o);
    end
    @(negedge clk);
    rst = 0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_priority();
    quiet();
    valid_i = 1; pc_i = 64'h8000_0010; src_except_i = 2'b11;
    src_cause_i = {64'd5, 64'd2}; src_tval_i = {64'hBBBB, 64'hAAAA};
    #1;
    total++;
    if (except_happen_o !== 1'b1) begin
      bad++; $display("FAIL prio_happen: got %b required 1", except_happen_o);
    end
    tick();
    total++;
    if (except_o !== 1'b1 || cause_o !== 64'd2 || epc_o !== 64'h8000_0010 ||
        tval_o !== 64'hAAAA || trap_req_o !== 1'b1) begin
      bad++;
      $display("FAIL prio_capture: exc=%b cause=%0d epc=%h tval=%h req=%b, required 1 2 80000010 aaaa 1",
               except_o, cause_o, epc_o, tval_o, trap_req_o);
    end
    ack();
    total++;
    if (except_o !== 1'b0 || trap_req_o !== 1'b0) begin
      bad++; $display("FAIL prio_ack: exc=%b req=%b required 0 0", except_o, trap_req_o);
    end
  endtask

  task automatic test_upstream();
    quiet();
    valid_i = 1; up_except_i = 1; up_cause_i = 64'd12; up_tval_i = 64'h1234;
    src_except_i = 2'b01; src_cause_i[XLEN-1:0] = 64'd7;
    #1;
    total++;
    if (except_happen_o !== 1'b0) begin
      bad++; $display("FAIL up_happen: got %b required 0", except_happen_o);
    end
    tick();
    total++;
    if (cause_o !== 64'd12 || tval_o !== 64'h1234 || except_o !== 1'b1) begin
      bad++; $display("FAIL up_cause: cause=%0d tval=%h exc=%b required 12 1234 1", cause_o, tval_o, except_o);
    end
    ack();
    up_except_i = 1; up_cause_i = 64'd13; valid_i = 0; pc_i = 64'h40;
    tick();
    quiet();
    total++;
    if (except_o !== 1'b1 || cause_o !== 64'd13 || epc_o !== 64'h40) begin
      bad++; $display("FAIL up_novalid: exc=%b cause=%0d epc=%h required 1 13 40", except_o, cause_o, epc_o);
    end
    ack();
  endtask

  task automatic test_pend_hold();
    logic [31:0] cnt_before;
    capture_src(64'h100, 64'd4);
    for (int i = 0; i < 3; i++) begin
      valid_i = 1; src_except_i = 2'b10; pc_i = 64'h200 + XLEN'(i);
      src_cause_i = {rnd64(), rnd64()};
      #1;
      total++;
      if (except_happen_o !== 1'b0) begin
        bad++; $display("FAIL hold_happen[%0d]: got %b required 0", i, except_happen_o);
      end
      tick();
      total++;
      if (except_o !== 1'b1 || epc_o !== 64'h100 || cause_o !== 64'd4 || trap_req_o !== 1'b1) begin
        bad++; $display("FAIL hold[%0d]: exc=%b epc=%h cause=%0d req=%b required 1 100 4 1",
                        i, except_o, epc_o, cause_o, trap_req_o);
      end
    end
    cnt_before = m_cnt;
    ack();
    total++;
    if (except_o !== 1'b0 || trap_req_o !== 1'b0 || trap_cnt_o !== m_cnt) begin
      bad++; $display("FAIL hold_ack: exc=%b req=%b cnt=%0d required 0 0 %0d (before %0d)",
                      except_o, trap_req_o, trap_cnt_o, m_cnt, cnt_before);
    end
  endtask

  task automatic test_stall_flush();
    quiet();
    stall = 1; valid_i = 1; src_except_i = 2'b01; pc_i = 64'h300; src_cause_i[XLEN-1:0] = 64'd9;
    tick();
    total++;
    if (except_o !== 1'b0 || epc_o !== '0 || trap_req_o !== 1'b0) begin
      bad++; $display("FAIL stall_idle: exc=%b epc=%h req=%b required 0 0 0", except_o, epc_o, trap_req_o);
    end
    capture_src(64'h310, 64'd3);
    stall = 1; flush = 1;
    tick();
    quiet();
    total++;
    if (except_o !== 1'b0 || cause_o !== '0 || trap_req_o !== 1'b0) begin
      bad++; $display("FAIL stall_flush: exc=%b cause=%0d req=%b required 0 0 0", except_o, cause_o, trap_req_o);
    end
  endtask

  task automatic test_flush_ack();
    logic [31:0] cnt_before;
    capture_src(64'h400, 64'd6);
    cnt_before = m_cnt;
    flush = 1; trap_ack_i = 1;
    tick();
    quiet();
    total++;
    if (except_o !== 1'b0 || trap_req_o !== 1'b0 || trap_cnt_o !== m_cnt) begin
      bad++; $display("FAIL flush_ack: exc=%b req=%b cnt=%0d required 0 0 %0d (before %0d)",
                      except_o, trap_req_o, trap_cnt_o, m_cnt, cnt_before);
    end
    capture_src(64'h410, 64'd8);
    total++;
    if (except_o !== 1'b1 || cause_o !== 64'd8) begin
      bad++; $display("FAIL after_flush_capture: exc=%b cause=%0d required 1 8", except_o, cause_o);
    end
    ack();
  endtask

  task automatic test_async_reset();
    capture_src(64'h500, 64'd11);
    ack();
    capture_src(64'h510, 64'd1);
    #3;
    rst = 1;
    model_reset();
    #1;
    total++;
    if ({except_o, epc_o, cause_o, tval_o, trap_req_o, trap_cnt_o} !== '0) begin
      bad++; $display("FAIL async_rst: exc=%b epc=%h req=%b cnt=%0d required all 0",
                      except_o, epc_o, trap_req_o, trap_cnt_o);
    end
    @(negedge clk);
    rst = 0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_counter();
    for (int i = 0; i < 4; i++) begin
      capture_src(64'h600 + XLEN'(i), 64'd2);
      ack();
    end
    total++;
`ifdef EXCEPT_PERF_CNT_EN
    if (trap_cnt_o !== 32'd4) begin
      bad++; $display("FAIL cnt4: got %0d required 4", trap_cnt_o);
    end
    dut.trap_cnt_q = 32'hFFFF_FFFF;
    m_cnt = 32'hFFFF_FFFF;
    capture_src(64'h700, 64'd2);
    ack();
    total++;
    if (trap_cnt_o !== 32'hFFFF_FFFF) begin
      bad++; $display("FAIL cnt_sat: got %h required ffffffff", trap_cnt_o);
    end
`else
    if (trap_cnt_o !== 32'd0) begin
      bad++; $display("FAIL cnt_off: got %0d required 0", trap_cnt_o);
    end
`endif
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      stall        = ($urandom_range(0, 3) == 0);
      flush        = ($urandom_range(0, 15) == 0);
      valid_i      = ($urandom_range(0, 3) != 0);
      up_except_i  = ($urandom_range(0, 5) == 0);
      trap_ack_i   = ($urandom_range(0, 2) == 0);
      src_except_i = NSRC'($urandom_range(0, 3));
      pc_i = rnd64(); up_cause_i = rnd64(); up_tval_i = rnd64();
      src_cause_i = {rnd64(), rnd64()}; src_tval_i = {rnd64(), rnd64()};
      #1;
      total++;
      if (except_happen_o !== exp_happen()) begin
        bad++; $display("FAIL rnd_happen[%0d]: got %b required %b", n, except_happen_o, exp_happen());
      end
      tick();
      total++;
      if (except_o !== m_exc || epc_o !== m_epc || cause_o !== m_cause || tval_o !== m_tval ||
          trap_req_o !== m_pend || trap_cnt_o !== m_cnt) begin
        bad++;
        $display("FAIL rnd_out[%0d]: exc=%b epc=%h cause=%h tval=%h req=%b cnt=%0d required %b %h %h %h %b %0d",
                 n, except_o, epc_o, cause_o, tval_o, trap_req_o, trap_cnt_o,
                 m_exc, m_epc, m_cause, m_tval, m_pend, m_cnt);
      end
    end
    quiet();
  endtask

  initial begin
    test_reset();
    test_priority();
    test_upstream();
    test_pend_hold();
    test_stall_flush();
    test_flush_ack();
    test_async_reset();
    test_counter();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
